// File: rtl/pipeline_register_pkg.sv
// Shared defaults for the elastic pipeline register slice.
// Widths that depend on STAGES are derived inside the modules that use them.
package pipeline_register_pkg;
  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_STAGES = 2;
endpackage

// File: rtl/pipeline_register_pipe_stage.sv
// One elastic stage: a valid/data register with a combinational ready chain.
// An empty stage is always ready, so bubbles collapse under downstream stall.
module pipe_stage
  import pipeline_register_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ready
);

  assign ready = !valid || down_ready;

  // Flush drops the word but leaves the data register untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (ready) begin
      valid <= up_valid;
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/pipeline_register.sv
// Elastic pipeline of STAGES pipe_stage registers with flush and an occupancy count.
// Handshake: a word moves across a port only on an edge where valid and ready are both 1.
module pipeline_register
  import pipeline_register_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH-1:0]            in,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            out,
  output logic                        out_valid,
  input  logic                        out_ready,
  input  logic                        flush,
  output logic [$clog2(STAGES+1)-1:0] count
);

  localparam int CW = $clog2(STAGES + 1);

  logic [STAGES-1:0] valid_s;
  logic [STAGES:0]   ready_s;
  logic [WIDTH-1:0]  data_s [STAGES];
  logic              accept;
  logic              emit;
  logic [CW-1:0]     count_q;

  assign ready_s[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = in;
    end else begin : g_body
      assign up_valid = valid_s[k-1];
      assign up_data  = data_s[k-1];
    end

    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .up_valid   (up_valid),
      .up_data    (up_data),
      .down_ready (ready_s[k+1]),
      .valid      (valid_s[k]),
      .data       (data_s[k]),
      .ready      (ready_s[k])
    );
  end

  assign in_ready  = ready_s[0] && !flush;
  assign out       = data_s[STAGES-1];
  assign out_valid = valid_s[STAGES-1];

  // Occupancy tracks the valid bits: +1 on accept, -1 on a completed emit.
  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(accept) - CW'(emit);
    end
  end

  assign count = count_q;

endmodule
